// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are shadowed at issue so results never depend on the live E-stage inputs.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no operation in flight; accepts start, mthi and mtlo
// S_BUSY | counting down; HI/LO are written when the counter reaches 1
module mdu_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [3:0]  op_sh;
    logic [31:0] a_sh;
    logic [31:0] b_sh;

    logic        is_md_op;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    assign is_md_op = (MDU_op >= OP_MULT) && (MDU_op <= OP_DIVU);

    assign prod_s = $signed({{32{a_sh[31]}}, a_sh}) * $signed({{32{b_sh[31]}}, b_sh});
    assign prod_u = {32'd0, a_sh} * {32'd0, b_sh};

    // Signed division on magnitudes avoids the 0x80000000 / -1 overflow trap.
    assign a_neg = (op_sh == OP_DIV) && a_sh[31];
    assign b_neg = (op_sh == OP_DIV) && b_sh[31];
    assign a_mag = a_neg ? (~a_sh + 32'd1) : a_sh;
    assign b_mag = b_neg ? (~b_sh + 32'd1) : b_sh;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        unique case (op_sh)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
                res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
                res_wr = (b_sh != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            op_sh <= 4'd0;
            a_sh  <= 32'd0;
            b_sh  <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && is_md_op) begin
                        state <= S_BUSY;
                        busy  <= 1'b1;
                        op_sh <= MDU_op;
                        a_sh  <= A;
                        b_sh  <= B;
                        cnt   <= (MDU_op <= OP_MULTU) ? 4'd5 : 4'd10;
                    end else if (MDU_op == OP_MTHI) begin
                        HI <= A;
                    end else if (MDU_op == OP_MTLO) begin
                        LO <= A;
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                        if (res_wr) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign MDU_out = (MDU_op == OP_MFHI) ? HI :
                     (MDU_op == OP_MFLO) ? LO : 32'd0;

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL provide port `clk`, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port `reset`, input, 1 bit: synchronous, active-high; sampled on the rising edge of clk.
REQ-004 The block SHALL provide port `start`, input, 1 bit: E-stage multiply/divide issue pulse, qualified by MDU_op.
REQ-005 The block SHALL provide port `MDU_op`, input, 4 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-006 The block SHALL provide ports `A` and `B`, input, 32 bits each: forwarded E-stage rs and rt operands.
REQ-007 The block SHALL provide port `busy`, output, 1 bit: operation in flight; the hazard unit stalls D on MD-class instructions when (start | busy).
REQ-008 The block SHALL provide ports `HI` and `LO`, output, 32 bits each: architectural HI/LO register contents.
REQ-009 The block SHALL provide port `MDU_out`, output, 32 bits: HI when MDU_op=5, LO when MDU_op=6, else 0; combinational from the HI/LO registers.

Function
REQ-010 The block SHALL define an accepted start as start=1 with MDU_op in 1..4, busy=0 and reset=0.
REQ-011 On an accepted start the block SHALL latch A, B and MDU_op into internal shadow registers, set busy=1 and load the cycle counter with 5 (mult/multu) or 10 (div/divu).
REQ-012 The block SHALL ignore start when busy=1: no operand latch, no counter reload and no HI/LO change.
REQ-013 The block SHALL ignore start with MDU_op outside 1..4.
REQ-014 The block SHALL keep busy=1 for exactly N consecutive cycles following the start cycle, with N=5 for mult/multu and N=10 for div/divu.
REQ-015 The block SHALL decrement the counter once per cycle while busy=1.
REQ-016 On the edge where the counter reaches 1, the block SHALL write HI/LO and clear busy; the new values are visible in the first cycle with busy=0.
REQ-017 The mult operation SHALL write {HI,LO} = signed 32x32 -> 64-bit product of the latched operands.
REQ-018 The multu operation SHALL write {HI,LO} = the unsigned 64-bit product of the latched operands.
REQ-019 The div operation SHALL write LO = signed quotient truncated toward zero and HI = remainder carrying the dividend's sign.
REQ-020 The divu operation SHALL write LO and HI from unsigned division.
REQ-021 When the latched divisor is 0, the block SHALL leave HI and LO unchanged while busy timing stays identical.
REQ-022 For div with 0x80000000 / 0xFFFFFFFF, the block SHALL write LO=0x80000000 and HI=0.
REQ-023 The results SHALL depend only on the shadow registers; changes on A/B/MDU_op during busy SHALL have no effect.
REQ-024 MDU_op=7 (mthi) with busy=0 SHALL write HI=A at the next edge.
REQ-025 MDU_op=8 (mtlo) with busy=0 SHALL write LO=A at the next edge.
REQ-026 mthi/mtlo SHALL be independent of start.
REQ-027 mthi/mtlo with busy=1 SHALL be ignored.
REQ-028 MDU_out SHALL reflect register state only, never an in-flight result.
REQ-029 A result write on the final busy edge and a completion cycle with no new start SHALL leave busy=0 thereafter.
REQ-030 A new start SHALL be accepted in the very first cycle busy=0.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL set HI=0, LO=0, busy=0, counter=0 and shadow registers=0.
REQ-032 Reset SHALL have priority over start, mthi/mtlo and completion.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no HI/LO write.
REQ-034 After reset deasserts, the block SHALL be idle and accept start in the first cycle.

Verification
REQ-035 The bench SHALL apply mult with A=0xFFFFFFFE and B=3, start for one cycle, and check busy=1 for 5 cycles then HI=0xFFFFFFFF and LO=0xFFFFFFFA with busy=0.
REQ-036 The bench SHALL apply multu with the same operands and check HI=0x00000002 and LO=0xFFFFFFFA after 5 busy cycles.
REQ-037 The bench SHALL apply div with A=-7 and B=2, check busy for 10 cycles, then check LO=0xFFFFFFFD and HI=0xFFFFFFFF; it SHALL then apply divu with B=0 and check HI/LO unchanged and busy low after 10 cycles.
REQ-038 The bench SHALL change A/B and pulse start and mthi mid-operation and check the result matches the original operands, the counter is not reloaded and HI is not overwritten.
REQ-039 The bench SHALL apply mtlo with A=0x12345678, then mflo, and check MDU_out=0x12345678 in the cycle after the write edge.
REQ-040 The bench SHALL assert reset in busy cycle 3 of a div and check busy=0 and HI=LO=0 on the next cycle, then check that a fresh mult completes correctly.
